// File: rtl/exe_mem_skid_reg_pkg.sv
// Shared types for the EXE/MEM skid register: control word layout, default
// payload layout, handshake state encoding and a payload width helper.
package exe_mem_skid_reg_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 16;
    localparam int DEF_REG_W  = 5;
    localparam int DEF_FUNC_W = 6;
    localparam int DEF_CNT_W  = 16;

    // Packed control word produced by the decoder, 16 bits total.
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       jump_reg;
        logic       link;
        logic       alu_src;
        logic       reg_dst;
        logic [4:0] alu_op;
    } ControlSignal;

    // Default-width payload; parametrised instances rebuild the same field order.
    typedef struct packed {
        ControlSignal            cs;
        logic                    zero_flag;
        logic [DEF_DATA_W-1:0]   alu_res;
        logic [DEF_DATA_W-1:0]   data_to_mem;
        logic [DEF_REG_W-1:0]    write_reg;
        logic [DEF_DATA_W-1:0]   pc_plus4;
        logic [DEF_FUNC_W-1:0]   func;
    } exe_mem_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    function automatic int payload_width(input int data_w, input int ctrl_w,
                                         input int reg_w, input int func_w);
        return ctrl_w + 1 + 3 * data_w + reg_w + func_w;
    endfunction

endpackage

// File: rtl/exe_mem_skid_reg_slot.sv
// One payload slot: a register with a valid bit; clear beats load so a squash
// always wins over a simultaneous refill.
module pipe_payload_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic         valid_o
);

    logic [W-1:0] payload_q;
    logic         valid_q;

    // Pipeline stages update on the falling edge of the stage clock.
    always_ff @(negedge clk) begin
        if (srst) begin
            payload_q <= '0;
            valid_q   <= 1'b0;
        end else if (clear_i) begin
            valid_q   <= 1'b0;
        end else if (load_i) begin
            payload_q <= d_i;
            valid_q   <= 1'b1;
        end
    end

    assign q_o     = payload_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/exe_mem_skid_reg.sv
// EXE/MEM pipeline register with valid/ready handshake, a two-entry skid buffer,
// synchronous flush and a saturating backpressure counter.
module exe_mem_skid_reg
    import exe_mem_skid_reg_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CTRL_W    = DEF_CTRL_W,
    parameter int REG_W     = DEF_REG_W,
    parameter int FUNC_W    = DEF_FUNC_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter bit KILL_CTRL = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_cs,
    input  logic              in_zero_flag,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_data_to_mem,
    input  logic [REG_W-1:0]  in_write_reg,
    input  logic [DATA_W-1:0] in_pc_plus4,
    input  logic [FUNC_W-1:0] in_func,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_cs,
    output logic              out_zero_flag,
    output logic [DATA_W-1:0] out_alu_res,
    output logic [DATA_W-1:0] out_data_to_mem,
    output logic [REG_W-1:0]  out_write_reg,
    output logic [DATA_W-1:0] out_pc_plus4,
    output logic [FUNC_W-1:0] out_func,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic [CTRL_W-1:0] cs;
        logic              zero_flag;
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] data_to_mem;
        logic [REG_W-1:0]  write_reg;
        logic [DATA_W-1:0] pc_plus4;
        logic [FUNC_W-1:0] func;
    } payload_t;

    localparam int PAYLOAD_W = payload_width(DATA_W, CTRL_W, REG_W, FUNC_W);
    localparam int MAIN = 0;
    localparam int SKID = 1;

    payload_t            in_payload;
    payload_t            main_q;
    logic [PAYLOAD_W-1:0] slot_d     [2];
    logic [PAYLOAD_W-1:0] slot_q     [2];
    logic                 slot_load  [2];
    logic                 slot_clear [2];
    logic                 slot_valid [2];

    skid_state_e          state_q, state_d;
    logic [CNT_W-1:0]     stall_q, stall_d;
    logic                 accept, issue, main_from_skid;

    assign in_payload = '{cs: in_cs, zero_flag: in_zero_flag, alu_res: in_alu_res,
                          data_to_mem: in_data_to_mem, write_reg: in_write_reg,
                          pc_plus4: in_pc_plus4, func: in_func};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            pipe_payload_slot #(
                .W (PAYLOAD_W)
            ) u_slot (
                .clk     (clock),
                .srst    (reset),
                .load_i  (slot_load[gi]),
                .clear_i (slot_clear[gi]),
                .d_i     (slot_d[gi]),
                .q_o     (slot_q[gi]),
                .valid_o (slot_valid[gi])
            );
        end
    endgenerate

    assign slot_d[MAIN] = main_from_skid ? slot_q[SKID] : in_payload;
    assign slot_d[SKID] = in_payload;
    assign main_q       = slot_q[MAIN];

    // in_ready comes straight from the skid valid flop, never from out_ready.
    assign in_ready  = !slot_valid[SKID];
    assign out_valid = slot_valid[MAIN];
    assign accept    = in_valid && in_ready;
    assign issue     = out_valid && out_ready;

    always_comb begin
        state_d          = state_q;
        slot_load[MAIN]  = 1'b0;
        slot_load[SKID]  = 1'b0;
        slot_clear[MAIN] = 1'b0;
        slot_clear[SKID] = 1'b0;
        main_from_skid   = 1'b0;
        if (flush) begin
            state_d          = EMPTY;
            slot_clear[MAIN] = 1'b1;
            slot_clear[SKID] = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        slot_load[MAIN] = 1'b1;
                        state_d         = ONE;
                    end
                end
                ONE: begin
                    if (accept && issue) begin
                        slot_load[MAIN] = 1'b1;
                    end else if (accept && !out_ready) begin
                        slot_load[SKID] = 1'b1;
                        state_d         = FULL;
                    end else if (issue) begin
                        slot_clear[MAIN] = 1'b1;
                        state_d          = EMPTY;
                    end
                end
                FULL: begin
                    if (issue) begin
                        slot_load[MAIN]  = 1'b1;
                        main_from_skid   = 1'b1;
                        slot_clear[SKID] = 1'b1;
                        state_d          = ONE;
                    end
                end
                default: begin
                    state_d          = EMPTY;
                    slot_clear[MAIN] = 1'b1;
                    slot_clear[SKID] = 1'b1;
                end
            endcase
        end
    end

    // A squash cycle is not counted as backpressure.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && !flush && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    assign out_cs          = (KILL_CTRL && !out_valid) ? '0 : main_q.cs;
    assign out_zero_flag   = main_q.zero_flag;
    assign out_alu_res     = main_q.alu_res;
    assign out_data_to_mem = main_q.data_to_mem;
    assign out_write_reg   = main_q.write_reg;
    assign out_pc_plus4    = main_q.pc_plus4;
    assign out_func        = main_q.func;
    assign stall_count     = stall_q;

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Directed bench for exe_mem_skid_reg: a queue of expected ALU results is
// checked in order by an independent monitor; three instances cover CNT_W/KILL_CTRL.
module tb_exe_mem_skid_reg;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_cs;
    logic        in_zero_flag;
    logic [31:0] in_alu_res, in_data_to_mem, in_pc_plus4;
    logic [4:0]  in_write_reg;
    logic [5:0]  in_func;

    logic        in_ready, out_valid, out_zero_flag;
    logic [15:0] out_cs, stall_count;
    logic [31:0] out_alu_res, out_data_to_mem, out_pc_plus4;
    logic [4:0]  out_write_reg;
    logic [5:0]  out_func;

    logic        s_in_ready, s_out_valid, s_out_zero_flag;
    logic [15:0] s_out_cs;
    logic [3:0]  s_stall_count;
    logic [31:0] s_out_alu_res, s_out_data_to_mem, s_out_pc_plus4;
    logic [4:0]  s_out_write_reg;
    logic [5:0]  s_out_func;

    logic        n_in_ready, n_out_valid, n_out_zero_flag;
    logic [15:0] n_out_cs, n_stall_count;
    logic [31:0] n_out_alu_res, n_out_data_to_mem, n_out_pc_plus4;
    logic [4:0]  n_out_write_reg;
    logic [5:0]  n_out_func;

    logic [123:0] dut_out;
    logic [31:0]  sb[$];
    int           total = 0;
    int           bad = 0;

    exe_mem_skid_reg dut (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_cs(in_cs), .in_zero_flag(in_zero_flag), .in_alu_res(in_alu_res),
        .in_data_to_mem(in_data_to_mem), .in_write_reg(in_write_reg), .in_pc_plus4(in_pc_plus4),
        .in_func(in_func), .out_valid(out_valid), .out_ready(out_ready), .out_cs(out_cs),
        .out_zero_flag(out_zero_flag), .out_alu_res(out_alu_res), .out_data_to_mem(out_data_to_mem),
        .out_write_reg(out_write_reg), .out_pc_plus4(out_pc_plus4), .out_func(out_func),
        .stall_count(stall_count)
    );

    exe_mem_skid_reg #(.CNT_W(4)) dut_sat (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_cs(in_cs), .in_zero_flag(in_zero_flag), .in_alu_res(in_alu_res),
        .in_data_to_mem(in_data_to_mem), .in_write_reg(in_write_reg), .in_pc_plus4(in_pc_plus4),
        .in_func(in_func), .out_valid(s_out_valid), .out_ready(out_ready), .out_cs(s_out_cs),
        .out_zero_flag(s_out_zero_flag), .out_alu_res(s_out_alu_res),
        .out_data_to_mem(s_out_data_to_mem), .out_write_reg(s_out_write_reg),
        .out_pc_plus4(s_out_pc_plus4), .out_func(s_out_func), .stall_count(s_stall_count)
    );

    exe_mem_skid_reg #(.KILL_CTRL(1'b0)) dut_nk (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_cs(in_cs), .in_zero_flag(in_zero_flag), .in_alu_res(in_alu_res),
        .in_data_to_mem(in_data_to_mem), .in_write_reg(in_write_reg), .in_pc_plus4(in_pc_plus4),
        .in_func(in_func), .out_valid(n_out_valid), .out_ready(out_ready), .out_cs(n_out_cs),
        .out_zero_flag(n_out_zero_flag), .out_alu_res(n_out_alu_res),
        .out_data_to_mem(n_out_data_to_mem), .out_write_reg(n_out_write_reg),
        .out_pc_plus4(n_out_pc_plus4), .out_func(n_out_func), .stall_count(n_stall_count)
    );

    always #5 clock = ~clock;

    assign dut_out = {out_cs, out_zero_flag, out_alu_res, out_data_to_mem,
                      out_write_reg, out_pc_plus4, out_func};

    // Every payload field is derived from the ALU value so one number identifies an entry.
    function automatic logic [123:0] pat(input logic [31:0] a);
        logic [15:0] cs;
        cs = {a[7:0], 8'h5A};
        return {cs, (a == 32'd0), a, ~a, a[4:0], a + 32'd4, a[9:4]};
    endfunction

    task automatic set_in(input logic [31:0] a);
        {in_cs, in_zero_flag, in_alu_res, in_data_to_mem, in_write_reg, in_pc_plus4, in_func} = pat(a);
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, exp);
        end else begin
            $display("ok   %s value=%0h", name, got);
        end
    endtask

    // One stage cycle: inputs change just after the rising edge, DUT updates on the falling edge.
    task automatic cycle(input bit rst, input bit v, input logic [31:0] a,
                         input bit rdy, input bit fl, input bit push);
        @(posedge clock);
        #1;
        reset = rst; in_valid = v; out_ready = rdy; flush = fl;
        set_in(a);
        if (push) sb.push_back(a);
        @(negedge clock);
        #1;
        if (fl || rst) sb.delete();
    endtask

    // Monitor: just before each falling edge, an issuing entry must match the queue head.
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge clock);
            #3;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL issue_unexpected got_alu=%0h want=none", out_alu_res);
                end else begin
                    e = sb.pop_front();
                    if (dut_out !== pat(e)) begin
                        bad++;
                        $display("FAIL issue got=%0h want=%0h", dut_out, pat(e));
                    end else begin
                        $display("ok   issue alu=%0h", out_alu_res);
                    end
                end
            end else if (out_valid === 1'b0) begin
                total++;
                if (out_cs !== 16'h0) begin
                    bad++;
                    $display("FAIL bubble_cs got=%0h want=0", out_cs);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "timeout");
    end

    initial begin
        set_in(32'd0);
        cycle(1, 0, 32'h0, 0, 0, 0);
        cycle(1, 0, 32'h0, 0, 0, 0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_stall", stall_count, 16'd0);
        chk("rst_alu", out_alu_res, 32'h0);
        chk("rst_cs", out_cs, 16'h0);

        // Streaming
        cycle(0, 1, 32'h10, 1, 0, 1);
        chk("s1_valid", out_valid, 1'b1);
        chk("s1_alu", out_alu_res, 32'h10);
        cycle(0, 1, 32'h20, 1, 0, 1);
        chk("s2_alu", out_alu_res, 32'h20);
        cycle(0, 1, 32'h30, 1, 0, 1);
        chk("s3_alu", out_alu_res, 32'h30);
        cycle(0, 0, 32'h0, 1, 0, 0);
        chk("s_drain_valid", out_valid, 1'b0);
        chk("s_stall", stall_count, 16'd0);

        // Backpressure
        cycle(0, 1, 32'h10, 1, 0, 1);
        cycle(0, 1, 32'h20, 0, 0, 1);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_hold_alu", out_alu_res, 32'h10);
        cycle(0, 0, 32'h0, 0, 0, 0);
        cycle(0, 1, 32'h99, 0, 0, 0);
        chk("bp_stall", stall_count, 16'd3);
        chk("bp_still_10", out_alu_res, 32'h10);
        cycle(0, 0, 32'h0, 1, 0, 0);
        chk("bp_next_alu", out_alu_res, 32'h20);
        chk("bp_ready_back", in_ready, 1'b1);
        cycle(0, 0, 32'h0, 1, 0, 0);
        chk("bp_empty", out_valid, 1'b0);
        chk("bp_stall_keep", stall_count, 16'd3);

        // Flush while FULL, with a discarded accept
        cycle(0, 1, 32'hA, 0, 0, 1);
        cycle(0, 1, 32'hB, 0, 0, 1);
        chk("fl_full", in_ready, 1'b0);
        cycle(0, 1, 32'hC, 0, 1, 0);
        chk("fl_valid", out_valid, 1'b0);
        chk("fl_in_ready", in_ready, 1'b1);
        chk("fl_cs", out_cs, 16'h0);
        chk("fl_stall", stall_count, 16'd4);
        cycle(0, 0, 32'h0, 1, 0, 0);
        chk("fl_stays_empty", out_valid, 1'b0);
        cycle(0, 1, 32'h40, 1, 0, 1);
        chk("fl_new_alu", out_alu_res, 32'h40);
        cycle(0, 0, 32'h0, 1, 1, 0);
        chk("fl_issue_empty", out_valid, 1'b0);

        // Reset while FULL
        cycle(0, 1, 32'h50, 0, 0, 1);
        cycle(0, 1, 32'h60, 0, 0, 1);
        chk("rs_full", in_ready, 1'b0);
        chk("rs_stall_pre", stall_count, 16'd5);
        cycle(1, 0, 32'h0, 0, 0, 0);
        chk("rs_valid", out_valid, 1'b0);
        chk("rs_in_ready", in_ready, 1'b1);
        chk("rs_stall", stall_count, 16'd0);
        chk("rs_alu", out_alu_res, 32'h0);
        chk("rs_pc", out_pc_plus4, 32'h0);
        chk("rs_sat_stall", s_stall_count, 4'd0);

        // Saturation (CNT_W=4 instance)
        cycle(0, 1, 32'h70, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 32'h0, 0, 0, 0);
            if (i == 9) chk("sat_mid", s_stall_count, 4'd10);
        end
        chk("sat_top", s_stall_count, 4'd15);
        chk("sat_wide", stall_count, 16'd20);
        chk("sat_hold_alu", out_alu_res, 32'h70);
        cycle(0, 0, 32'h0, 1, 0, 0);

        // Bubble control
        cycle(0, 0, 32'hFF, 1, 0, 0);
        chk("kill_cs", out_cs, 16'h0);
        chk("nokill_valid", n_out_valid, 1'b0);
        chk("nokill_cs", n_out_cs, 16'h705A);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
